inst_sequencer: RTL and testbench

//  Fetches instructions from the synchronous instruction memory, expands REPEAT and consumes NOP/HALT,
//  and issues one datapath instruction per valid/ready handshake to the controller decoder.

---
 rtl/inst_sequencer_pkg.sv | 25 ++
 rtl/inst_sequencer_if.sv | 31 +++
 rtl/seq_repeat_counter.sv | 44 ++++
 rtl/inst_sequencer.sv | 144 ++++++++++++++
 tb/tb_inst_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared widths, opcode constants and FSM state type for the instruction sequencer.
package inst_sequencer_pkg;

  localparam int INST_MEM_DEPTH = 8;
  localparam int INST_MEM_SIZE  = 32;
  localparam int OPCODE_W       = 4;
  localparam int REPEAT_W       = 16;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_REPEAT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    DONE
  } seq_state_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_MEM_SIZE-1:0] word);
    return word[INST_MEM_SIZE-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Issue handshake between the sequencer (master) and the controller decoder (slave).
interface inst_sequencer_if
  import inst_sequencer_pkg::*;
#(
  parameter int INST_W = INST_MEM_SIZE,
  parameter int ITER_W = REPEAT_W
);

  logic              issue_valid;
  logic              issue_ready;
  logic [INST_W-1:0] issue_inst;
  logic [ITER_W-1:0] issue_iter;
  logic              issue_first;

  modport master (
    output issue_valid,
    output issue_inst,
    output issue_iter,
    output issue_first,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_inst,
    input  issue_iter,
    input  issue_first,
    output issue_ready
  );

endinterface

// File: rtl/seq_repeat_counter.sv
// Remaining-repeat counter and iteration index; last flags the final issue of a burst.
module seq_repeat_counter
  import inst_sequencer_pkg::*;
#(
  parameter int ITER_W = REPEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_first,
  input  logic              load_rep,
  input  logic              step,
  input  logic [ITER_W-1:0] count,
  output logic [ITER_W-1:0] iter,
  output logic              last
);

  logic [ITER_W-1:0] rep_left;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_left <= '0;
      iter     <= '0;
    end else if (load_first) begin
      rep_left <= '0;
      iter     <= '0;
    end else if (load_rep) begin
      // A REPEAT continues the iteration sequence of whatever was issued last.
      rep_left <= count;
      iter     <= iter + 1'b1;
    end else if (step) begin
      if (rep_left > ITER_W'(1)) begin
        rep_left <= rep_left - 1'b1;
        iter     <= iter + 1'b1;
      end else begin
        rep_left <= '0;
      end
    end
  end

  assign last = (rep_left <= ITER_W'(1));

endmodule

// File: rtl/inst_sequencer.sv
// Fetches from instruction memory, expands REPEAT, drops NOP/HALT and issues to the decoder.
module inst_sequencer
  import inst_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [INST_MEM_DEPTH-1:0] start_addr,
  input  logic                      abort,
  output logic [INST_MEM_DEPTH-1:0] inst_addr,
  input  logic [INST_MEM_SIZE-1:0]  inst_data,
  inst_sequencer_if.master          issue,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  seq_state_t                state, state_next;
  logic [INST_MEM_DEPTH-1:0] pc;
  logic [INST_MEM_SIZE-1:0]  issue_inst;
  logic [REPEAT_W-1:0]       issue_iter;
  logic                      last_valid;
  logic                      rep_last;

  logic                      load_start;
  logic                      pc_inc;
  logic                      take_inst;
  logic                      set_error;
  logic                      load_rep;
  logic                      step;

  logic [OPCODE_W-1:0]       opcode;
  logic [REPEAT_W-1:0]       count;
  logic                      handshake;

  assign opcode    = opcode_of(inst_data);
  assign count     = inst_data[REPEAT_W-1:0];
  assign handshake = (state == ISSUE) && issue.issue_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    pc_inc     = 1'b0;
    take_inst  = 1'b0;
    set_error  = 1'b0;
    load_rep   = 1'b0;
    step       = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            load_start = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: state_next = DECODE;
        DECODE: begin
          if (opcode == OP_HALT) begin
            state_next = DONE;
          end else if (opcode == OP_NOP) begin
            pc_inc     = 1'b1;
            state_next = FETCH;
          end else if (opcode == OP_REPEAT) begin
            // A zero-count REPEAT is a no-op even before anything was issued.
            if (count == '0) begin
              pc_inc     = 1'b1;
              state_next = FETCH;
            end else if (!last_valid) begin
              set_error  = 1'b1;
              state_next = DONE;
            end else begin
              load_rep   = 1'b1;
              state_next = ISSUE;
            end
          end else begin
            take_inst  = 1'b1;
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            step = 1'b1;
            if (rep_last) begin
              pc_inc     = 1'b1;
              state_next = FETCH;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      issue_inst <= '0;
      error      <= 1'b0;
      last_valid <= 1'b0;
    end else begin
      if (load_start) begin
        pc         <= start_addr;
        error      <= 1'b0;
        last_valid <= 1'b0;
      end
      if (pc_inc)    pc <= pc + 1'b1;
      if (set_error) error <= 1'b1;
      if (take_inst) begin
        issue_inst <= inst_data;
        last_valid <= 1'b1;
      end
    end
  end

  seq_repeat_counter #(.ITER_W(REPEAT_W)) u_rep (
    .clk        (clk),
    .reset      (reset),
    .load_first (take_inst),
    .load_rep   (load_rep),
    .step       (step),
    .count      (count),
    .iter       (issue_iter),
    .last       (rep_last)
  );

  assign inst_addr         = pc;
  assign issue.issue_valid = (state == ISSUE);
  assign issue.issue_inst  = issue_inst;
  assign issue.issue_iter  = issue_iter;
  assign issue.issue_first = (issue_iter == '0);
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench: small programs in a model memory, issues recorded and compared to hand values.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [INST_MEM_DEPTH-1:0] start_addr;
  logic                      abort;
  logic [INST_MEM_DEPTH-1:0] inst_addr;
  logic [INST_MEM_SIZE-1:0]  inst_data;
  logic                      busy;
  logic                      done;
  logic                      error;

  inst_sequencer_if bus ();

  inst_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .issue      (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  logic [INST_MEM_SIZE-1:0] mem [2**INST_MEM_DEPTH];
  always @(posedge clk) inst_data <= mem[inst_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [27:0] operand);
    return {op, operand};
  endfunction

  localparam logic [31:0] MATMUL = 32'h1000_0123;
  localparam logic [31:0] ACCMOV = 32'h2000_0456;

  // Per-run observations.
  int          iters [$];
  logic [31:0] insts [$];
  int          cycs  [$];
  bit          firsts[$];
  int          done_cnt;
  int          unstable;
  bit          finished;

  task automatic run_prog(input logic [7:0] addr, input bit toggle, input int abort_after);
    bit          held = 0;
    logic [31:0] held_inst = '0;
    int          held_iter = 0;
    iters.delete(); insts.delete(); cycs.delete(); firsts.delete();
    done_cnt = 0; unstable = 0; finished = 0;
    start_addr = addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (abort_after >= 0 && iters.size() == abort_after && bus.issue_valid) begin
        bus.issue_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(bus.issue_valid), 0);
        check("abort_busy", 32'(busy), 0);
        for (int k = 0; k < 4; k++) begin
          if (done) done_cnt++;
          @(negedge clk);
        end
        finished = 1;
        break;
      end
      bus.issue_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (bus.issue_valid && held &&
          (bus.issue_inst !== held_inst || 32'(bus.issue_iter) != held_iter))
        unstable++;
      if (bus.issue_valid && bus.issue_ready) begin
        iters.push_back(int'(bus.issue_iter));
        insts.push_back(bus.issue_inst);
        cycs.push_back(c);
        firsts.push_back(bus.issue_first);
        held = 0;
      end else if (bus.issue_valid) begin
        held      = 1;
        held_inst = bus.issue_inst;
        held_iter = int'(bus.issue_iter);
      end
      if (done) done_cnt++;
      if (c > 0 && !busy) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    bus.issue_ready = 1'b0;
    if (!finished) check("timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 2**INST_MEM_DEPTH; i++) mem[i] = mk(OP_NOP, 0);
    mem[40]  = MATMUL;             mem[41] = mk(OP_HALT, 0);
    mem[16]  = MATMUL;             mem[17] = mk(OP_REPEAT, 3);  mem[18] = mk(OP_HALT, 0);
    mem[32]  = mk(OP_REPEAT, 2);   mem[33] = mk(OP_HALT, 0);
    mem[255] = mk(OP_NOP, 0);      mem[0]  = mk(OP_REPEAT, 0);
    mem[1]   = ACCMOV;             mem[2]  = mk(OP_HALT, 0);
    mem[64]  = MATMUL;             mem[65] = mk(OP_REPEAT, 5);  mem[66] = mk(OP_HALT, 0);

    reset = 1'b1; start = 1'b0; start_addr = '0; abort = 1'b0; bus.issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(inst_addr), 0);
    check("rst_valid", 32'(bus.issue_valid), 0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 0);
    check("rst_inst", bus.issue_inst, 0);
    check("rst_iter", 32'(bus.issue_iter), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single instruction then HALT.
    run_prog(8'd40, 1'b0, -1);
    check("single_count", iters.size(), 1);
    if (iters.size() == 1) begin
      check("single_iter", iters[0], 0);
      check("single_first", 32'(firsts[0]), 1);
      check("single_inst", insts[0], MATMUL);
      check("single_latency", cycs[0], 2);
    end
    check("single_done", done_cnt, 1);

    // REPEAT 3 with ready held high.
    run_prog(8'd16, 1'b0, -1);
    check("rep_count", iters.size(), 4);
    if (iters.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rep_iter%0d", i), iters[i], i);
        check($sformatf("rep_inst%0d", i), insts[i], MATMUL);
        check($sformatf("rep_first%0d", i), 32'(firsts[i]), (i == 0) ? 1 : 0);
      end
      check("rep_b2b_a", cycs[2] - cycs[1], 1);
      check("rep_b2b_b", cycs[3] - cycs[2], 1);
    end
    check("rep_done", done_cnt, 1);

    // Same program with ready toggling.
    run_prog(8'd16, 1'b1, -1);
    check("tog_count", iters.size(), 4);
    check("tog_stable", unstable, 0);
    if (iters.size() == 4) check("tog_last_iter", iters[3], 3);

    // REPEAT with nothing issued before it.
    run_prog(8'd32, 1'b0, -1);
    check("err_count", iters.size(), 0);
    check("err_flag", 32'(error), 1);
    check("err_done", done_cnt, 1);
    run_prog(8'd40, 1'b0, -1);
    check("err_cleared", 32'(error), 0);

    // NOP, REPEAT 0, ACCMOV starting at the top address: pc wraps to 0.
    run_prog(8'd255, 1'b0, -1);
    check("wrap_count", iters.size(), 1);
    if (iters.size() == 1) begin
      check("wrap_inst", insts[0], ACCMOV);
      check("wrap_iter", iters[0], 0);
    end
    check("wrap_err", 32'(error), 0);

    // Abort inside a REPEAT 5 after two issues, then restart.
    run_prog(8'd64, 1'b0, 2);
    check("abort_issued", iters.size(), 2);
    check("abort_no_done", done_cnt, 0);
    run_prog(8'd64, 1'b0, -1);
    check("restart_count", iters.size(), 6);
    if (iters.size() == 6) begin
      check("restart_iter0", iters[0], 0);
      check("restart_iter5", iters[5], 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
